// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART command receiver and the servo command decoder.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } rx_state_e;

  localparam int unsigned SAMPLE_MID = 8;
  localparam int unsigned OVERSAMPLE = 16;

  // Command ranges the servo stage decodes from the held byte.
  localparam logic [7:0] POS_MIN  = 8'd1;
  localparam logic [7:0] POS_MAX  = 8'd16;
  localparam logic [7:0] STOR_MIN = 8'd103;
  localparam logic [7:0] STOR_MAX = 8'd113;

  // Round-to-nearest clocks per oversample tick.
  function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud,
                                           input int unsigned os);
    return (clk_hz + (baud * os) / 2) / (baud * os);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick: one-cycle pulse every baud_div() clocks.
module uart_baud_tick #(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  import uart_rx_pkg::*;

  localparam int unsigned Div  = baud_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;

  logic [CntW-1:0] cnt_q;

  assign tick = (cnt_q == CntW'(Div - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/uart_cmd_rx.sv
// 16x oversampled 8N1 UART receiver with held byte output and one-cycle strobes.
// Define UART_RX_PARITY_EN for an 8E1 frame with parity checking.
module uart_cmd_rx #(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RxD,
  output logic [7:0] RxD_data,
  output logic       RxD_data_ready,
  output logic       RxD_idle,
  output logic       frame_err,
  output logic       parity_err
);
  import uart_rx_pkg::*;

  logic tick;

  uart_baud_tick #(
    .CLK_HZ    (CLK_HZ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_baud_tick (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  logic       rxd_meta_q, rxd_sync_q;
  logic       s7_q, s8_q;
  rx_state_e  state_q, state_d;
  logic [3:0] samp_q, samp_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] data_q, data_d;
  logic       ready_q, ready_d;
  logic       ferr_q, ferr_d;
  logic       vote_now, vote;
`ifdef UART_RX_PARITY_EN
  logic       par_bad_q, par_bad_d;
  logic       perr_q, perr_d;
`endif

  assign vote_now = tick && (samp_q == 4'(SAMPLE_MID + 1));
  // Majority of counts 7, 8 and the live sample at count 9.
  assign vote = (s7_q & s8_q) | (s7_q & rxd_sync_q) | (s8_q & rxd_sync_q);

  always_comb begin
    state_d = state_q;
    samp_d  = tick ? samp_q + 4'd1 : samp_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    ready_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_d    = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (!rxd_sync_q) begin
          samp_d  = 4'd0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (vote_now) begin
          state_d = vote ? StIdle : StData;
          bit_d   = 3'd0;
        end
      end
      StData: begin
        if (vote_now) begin
          shift_d = {vote, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (vote_now) begin
          par_bad_d = vote != (^shift_q);
          state_d   = StStop;
        end
      end
`endif
      StStop: begin
        if (vote_now) begin
          if (vote) begin
            state_d = StIdle;
`ifdef UART_RX_PARITY_EN
            if (par_bad_q) begin
              perr_d = 1'b1;
            end else begin
              data_d  = shift_q;
              ready_d = 1'b1;
            end
`else
            data_d  = shift_q;
            ready_d = 1'b1;
`endif
          end else begin
            ferr_d  = 1'b1;
            samp_d  = 4'd0;
            state_d = StBreak;
          end
        end
      end
      StBreak: begin
        // Line must stay high for a whole bit time before we re-arm.
        if (!rxd_sync_q) begin
          samp_d = 4'd0;
        end else if (tick && samp_q == 4'd15) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      s7_q       <= 1'b1;
      s8_q       <= 1'b1;
      state_q    <= StIdle;
      samp_q     <= 4'd0;
      bit_q      <= 3'd0;
      shift_q    <= 8'h00;
      data_q     <= 8'h00;
      ready_q    <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      rxd_meta_q <= RxD;
      rxd_sync_q <= rxd_meta_q;
      if (tick && samp_q == 4'(SAMPLE_MID - 1)) s7_q <= rxd_sync_q;
      if (tick && samp_q == 4'(SAMPLE_MID)) s8_q <= rxd_sync_q;
      state_q    <= state_d;
      samp_q     <= samp_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      ready_q    <= ready_d;
      ferr_q     <= ferr_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
    end
  end

  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign RxD_data       = data_q;
  assign RxD_data_ready = ready_q;
  assign frame_err      = ferr_q;
  assign RxD_idle       = (state_q == StIdle);

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx, scaled to 4 clocks per tick (64 clocks per bit).
module tb_uart_cmd_rx;

  localparam int unsigned CLK_HZ = 6400000;
  localparam int unsigned BAUD   = 100000;
  localparam int          BIT    = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       RxD = 1'b1;
  logic [7:0] RxD_data;
  logic       RxD_data_ready, RxD_idle, frame_err, parity_err;

  int tests = 0;
  int fails = 0;
  int rdy_cnt = 0;
  int ferr_cnt = 0;
  int perr_cnt = 0;
  int clash_cnt = 0;
  logic [7:0] rx_log [0:15];
`ifdef UART_RX_PARITY_EN
  logic bad_par = 1'b0;
`endif

  uart_cmd_rx #(
    .CLK_HZ    (CLK_HZ),
    .BAUD      (BAUD),
    .OVERSAMPLE(16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .RxD           (RxD),
    .RxD_data      (RxD_data),
    .RxD_data_ready(RxD_data_ready),
    .RxD_idle      (RxD_idle),
    .frame_err     (frame_err),
    .parity_err    (parity_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (RxD_data_ready) begin
        rx_log[rdy_cnt[3:0]] <= RxD_data;
        rdy_cnt <= rdy_cnt + 1;
      end
      if (frame_err) ferr_cnt <= ferr_cnt + 1;
      if (parity_err) perr_cnt <= perr_cnt + 1;
      if ((frame_err || parity_err) && RxD_data_ready) clash_cnt <= clash_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    RxD = b;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ bad_par);
`endif
    send_bit(stop);
  endtask

  initial begin
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_data", 32'(RxD_data), 32'h00);
    check("rst_ready", 32'(RxD_data_ready), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_perr", 32'(parity_err), 32'd0);
    check("rst_idle", 32'(RxD_idle), 32'd1);
    repeat (2 * BIT) @(negedge clk);

    send_frame(8'h05, 1'b1);
    check("b05_count", rdy_cnt, 1);
    check("b05_log", 32'(rx_log[0]), 32'h05);
    repeat (3 * BIT) @(negedge clk);
    check("b05_held", 32'(RxD_data), 32'h05);
    check("b05_single", rdy_cnt, 1);

    send_frame(8'h67, 1'b1);
    send_frame(8'h03, 1'b1);
    check("b2b_count", rdy_cnt, 3);
    check("b2b_first", 32'(rx_log[1]), 32'h67);
    check("b2b_second", 32'(rx_log[2]), 32'h03);
    check("b2b_data", 32'(RxD_data), 32'h03);
    repeat (BIT) @(negedge clk);

    RxD = 1'b0;
    repeat (8) @(negedge clk);
    RxD = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    check("glitch_count", rdy_cnt, 3);
    check("glitch_idle", 32'(RxD_idle), 32'd1);
    check("glitch_data", 32'(RxD_data), 32'h03);

    send_frame(8'h6A, 1'b0);
    RxD = 1'b0;
    repeat (3 * BIT) @(negedge clk);
    check("brk_not_idle", 32'(RxD_idle), 32'd0);
    RxD = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    check("brk_ferr", ferr_cnt, 1);
    check("brk_count", rdy_cnt, 3);
    check("brk_data", 32'(RxD_data), 32'h03);
    check("brk_idle", 32'(RxD_idle), 32'd1);
    send_frame(8'h0B, 1'b1);
    check("b0b_count", rdy_cnt, 4);
    check("b0b_data", 32'(RxD_data), 32'h0B);
    repeat (BIT) @(negedge clk);

    // Abort 0x71 halfway through data bit 4 (a 1 bit, so no false start afterwards).
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'(8'h71 >> i));
    RxD = 1'b1;
    repeat (BIT / 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_data", 32'(RxD_data), 32'h00);
    check("mrst_idle", 32'(RxD_idle), 32'd1);
    repeat (12 * BIT) @(negedge clk);
    check("mrst_count", rdy_cnt, 4);
    send_frame(8'h71, 1'b1);
    check("b71_count", rdy_cnt, 5);
    check("b71_data", 32'(RxD_data), 32'h71);
    repeat (BIT) @(negedge clk);

`ifdef UART_RX_PARITY_EN
    bad_par = 1'b1;
    send_frame(8'h6F, 1'b1);
    check("par_bad_perr", perr_cnt, 1);
    check("par_bad_count", rdy_cnt, 5);
    check("par_bad_data", 32'(RxD_data), 32'h71);
    bad_par = 1'b0;
    repeat (BIT) @(negedge clk);
    send_frame(8'h6F, 1'b1);
    check("par_ok_count", rdy_cnt, 6);
    check("par_ok_data", 32'(RxD_data), 32'h6F);
    check("par_ok_perr", perr_cnt, 1);
`else
    check("no_par_perr", perr_cnt, 0);
`endif
    repeat (BIT) @(negedge clk);
    check("ferr_total", ferr_cnt, 1);
    check("err_ready_clash", clash_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
